// File: rtl/target_seq_pkg.sv
// Shared types for the target power sequencer.
//   state_t  : sequencer state codes exposed on state_o
//   owner_t  : which agent currently owns the target pins
//   cyc_load : converts a cycle count into a timer load value (0 behaves as 1)
package target_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OWNER_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF   = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RESET = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  typedef enum logic [OWNER_W-1:0] {
    OWN_NONE = 2'd0,
    OWN_GPIO = 2'd1,
    OWN_AVR  = 2'd2
  } owner_t;

  // The timer raises done when it reaches zero, so a state lasting n cycles loads n-1.
  function automatic int unsigned cyc_load(input int unsigned n);
    return (n == 32'd0) ? 32'd0 : n - 32'd1;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by all timed sequencer phases.
//   clk, reset_n : clock, async active-low reset
//   load         : load load_val this cycle (takes priority over counting)
//   load_val     : value loaded; done_c fires load_val+1 cycles after the load edge
//   done_c       : combinational, high for one cycle when an armed count hits zero
module seq_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;
  logic             armed;

  // Count down after a load; disarm once zero has been reported.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == '0) armed <= 1'b0;
      else           cnt   <= cnt - CNT_W'(1);
    end
  end

  assign done_c = armed && (cnt == '0);

endmodule

// File: rtl/target_power_seq.sv
// Target connector power / reset / pin-ownership sequencer.
// Optional overcurrent handling is enabled with `define TARGET_SEQ_OVERCURRENT_EN.
//   clk, reset_n     : clock (clk_usb), async active-low reset
//   power_on_i       : target power request
//   avrprog_req_i    : AVR programmer requests nRST/MOSI/SCK
//   gpio_nrst_en_i   : GPIO requests nRST; gpio_nrst_i is the driven value
//   ocp_fault_i      : overcurrent fault (macro builds only)
//   target_npower_o  : 1 = target unpowered
//   pins_highz_o     : 1 = all target pins float
//   nrst_oe_o/nrst_o : nRST output enable and value
//   avr_grant_o      : AVR programmer owns the pins
//   gpio_grant_o     : GPIO owns nRST
//   state_o          : current state code
//   busy_o           : state is neither OFF nor RUN
//   fault_o          : overcurrent fault latched (tied 0 without the macro)
module target_power_seq
  import target_seq_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RAMP_CYC  = 1000,
  parameter int unsigned RST_CYC   = 100,
  parameter int unsigned DRAIN_CYC = 32,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               power_on_i,
  input  logic               avrprog_req_i,
  input  logic               gpio_nrst_en_i,
  input  logic               gpio_nrst_i,
`ifdef TARGET_SEQ_OVERCURRENT_EN
  input  logic               ocp_fault_i,
`endif
  output logic               target_npower_o,
  output logic               pins_highz_o,
  output logic               nrst_oe_o,
  output logic               nrst_o,
  output logic               avr_grant_o,
  output logic               gpio_grant_o,
  output logic [STATE_W-1:0] state_o,
  output logic               busy_o,
  output logic               fault_o
);

  localparam logic [CNT_W-1:0] RAMP_LD  = CNT_W'(cyc_load(RAMP_CYC));
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(cyc_load(RST_CYC));
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(cyc_load(DRAIN_CYC));
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(cyc_load(GAP_CYC));

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d, desired_c;
  logic             gap_q, gap_d;
  logic             tmr_load_c, tmr_done_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             npower_d, highz_d, oe_d, nrst_d, avr_d, gpio_d, busy_d;
`ifdef TARGET_SEQ_OVERCURRENT_EN
  logic             fault_d;
`endif

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done_c   (tmr_done_c)
  );

  // Next state, ownership, timer control and next registered outputs.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gap_d      = gap_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    desired_c  = avrprog_req_i  ? OWN_AVR  :
                 gpio_nrst_en_i ? OWN_GPIO : OWN_NONE;

    case (state_q)
      ST_OFF: begin
        if (power_on_i) begin
          state_d    = ST_RAMP;
          tmr_load_c = 1'b1;
          tmr_val_c  = RAMP_LD;
        end
      end
      ST_RAMP, ST_RESET, ST_RUN: begin
        if (!power_on_i) begin
          state_d    = ST_DRAIN;
          tmr_load_c = 1'b1;
          tmr_val_c  = DRAIN_LD;
        end else if (state_q == ST_RAMP) begin
          if (tmr_done_c) begin
            state_d    = ST_RESET;
            tmr_load_c = 1'b1;
            tmr_val_c  = RST_LD;
          end
        end else if (state_q == ST_RESET) begin
          if (tmr_done_c) state_d = ST_RUN;
        end else if (gap_q) begin
          // Gap end takes whatever is requested now; mid-gap changes never restart it.
          if (tmr_done_c) begin
            owner_d = desired_c;
            gap_d   = 1'b0;
          end
        end else if (desired_c != owner_q) begin
          owner_d    = OWN_NONE;
          gap_d      = 1'b1;
          tmr_load_c = 1'b1;
          tmr_val_c  = GAP_LD;
        end
      end
      ST_DRAIN: begin
        // Power requests are ignored until OFF is reached.
        if (tmr_done_c) state_d = ST_OFF;
      end
      ST_FAULT: begin
        if (!power_on_i) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

`ifdef TARGET_SEQ_OVERCURRENT_EN
    // Fault wins over everything else, including a simultaneous power-off.
    if (ocp_fault_i && (state_q inside {ST_RAMP, ST_RESET, ST_RUN, ST_DRAIN})) begin
      state_d    = ST_FAULT;
      tmr_load_c = 1'b0;
    end
`endif

    // Ownership only exists while running.
    if (state_d != ST_RUN) begin
      owner_d = OWN_NONE;
      gap_d   = 1'b0;
    end

    npower_d = 1'b1;
    highz_d  = 1'b1;
    oe_d     = 1'b0;
    nrst_d   = 1'b1;
    avr_d    = 1'b0;
    gpio_d   = 1'b0;
    busy_d   = (state_d != ST_OFF) && (state_d != ST_RUN);
`ifdef TARGET_SEQ_OVERCURRENT_EN
    fault_d  = (state_d == ST_FAULT);
`endif

    case (state_d)
      ST_RAMP, ST_DRAIN: npower_d = 1'b0;
      ST_RESET: begin
        npower_d = 1'b0;
        highz_d  = 1'b0;
        oe_d     = 1'b1;
        nrst_d   = 1'b0;
      end
      ST_RUN: begin
        npower_d = 1'b0;
        highz_d  = 1'b0;
        case (owner_d)
          OWN_GPIO: begin
            oe_d   = 1'b1;
            nrst_d = gpio_nrst_i;
            gpio_d = 1'b1;
          end
          // AVR pins are driven at the top level from the USB SPI path.
          OWN_AVR: avr_d = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_OFF;
      owner_q         <= OWN_NONE;
      gap_q           <= 1'b0;
      target_npower_o <= 1'b1;
      pins_highz_o    <= 1'b1;
      nrst_oe_o       <= 1'b0;
      nrst_o          <= 1'b1;
      avr_grant_o     <= 1'b0;
      gpio_grant_o    <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      gap_q           <= gap_d;
      target_npower_o <= npower_d;
      pins_highz_o    <= highz_d;
      nrst_oe_o       <= oe_d;
      nrst_o          <= nrst_d;
      avr_grant_o     <= avr_d;
      gpio_grant_o    <= gpio_d;
      busy_o          <= busy_d;
    end
  end

  assign state_o = state_q;

`ifdef TARGET_SEQ_OVERCURRENT_EN
  // Fault flag follows FAULT state entry/exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault_o <= 1'b0;
    else          fault_o <= fault_d;
  end
`else
  assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_target_power_seq.sv
// Self-checking bench for target_power_seq (RAMP=8, RST=4, DRAIN=3, GAP=2).
// Fault scenario is exercised when TARGET_SEQ_OVERCURRENT_EN is defined.
module tb_target_power_seq;
  import target_seq_pkg::*;

  typedef struct packed {
    logic pwr;
    logic avr;
    logic gen;
    logic gnrst;
    logic ocp;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       power_on = 1'b0, avrprog_req = 1'b0, gpio_nrst_en = 1'b0, gpio_nrst = 1'b0;
`ifdef TARGET_SEQ_OVERCURRENT_EN
  logic       ocp_fault = 1'b0;
`endif
  logic       npower, highz, nrst_oe, nrst, avr_grant, gpio_grant, busy, fault;
  logic [2:0] state;

  stim_t       stim_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] e, o;
  stim_t       s;
  int          n_cmp = 0;
  int          n_fail = 0;

  target_power_seq #(
    .CNT_W(16), .RAMP_CYC(8), .RST_CYC(4), .DRAIN_CYC(3), .GAP_CYC(2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .power_on_i      (power_on),
    .avrprog_req_i   (avrprog_req),
    .gpio_nrst_en_i  (gpio_nrst_en),
    .gpio_nrst_i     (gpio_nrst),
`ifdef TARGET_SEQ_OVERCURRENT_EN
    .ocp_fault_i     (ocp_fault),
`endif
    .target_npower_o (npower),
    .pins_highz_o    (highz),
    .nrst_oe_o       (nrst_oe),
    .nrst_o          (nrst),
    .avr_grant_o     (avr_grant),
    .gpio_grant_o    (gpio_grant),
    .state_o         (state),
    .busy_o          (busy),
    .fault_o         (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {state, npower, highz, nrst_oe, nrst, avr, gpio, busy, fault}.
  function automatic logic [10:0] model(input state_t st, input owner_t own, input logic gn);
    logic np, hz, oe, nr, ag, gg, bz, fl;
    np = 1'b0; hz = 1'b1; oe = 1'b0; nr = 1'b1; ag = 1'b0; gg = 1'b0; bz = 1'b1; fl = 1'b0;
    case (st)
      ST_OFF:   begin np = 1'b1; bz = 1'b0; end
      ST_RESET: begin hz = 1'b0; oe = 1'b1; nr = 1'b0; end
      ST_RUN: begin
        hz = 1'b0; bz = 1'b0;
        if (own == OWN_GPIO) begin oe = 1'b1; nr = gn; gg = 1'b1; end
        if (own == OWN_AVR)  ag = 1'b1;
      end
      ST_FAULT: begin np = 1'b1; fl = 1'b1; end
      default: ;
    endcase
    return {3'(st), np, hz, oe, nr, ag, gg, bz, fl};
  endfunction

  function automatic logic [10:0] sample();
    return {state, npower, highz, nrst_oe, nrst, avr_grant, gpio_grant, busy, fault};
  endfunction

  task automatic sched(input logic pwr, input logic avr, input logic gen, input logic gn,
                       input logic ocp, input state_t st, input owner_t own);
    stim_q.push_back('{pwr, avr, gen, gn, ocp});
    exp_q.push_back(model(st, own, gn));
  endtask

  task automatic drive(input stim_t d);
    power_on = d.pwr; avrprog_req = d.avr; gpio_nrst_en = d.gen; gpio_nrst = d.gnrst;
`ifdef TARGET_SEQ_OVERCURRENT_EN
    ocp_fault = d.ocp;
`endif
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(model(ST_OFF, OWN_NONE, 1'b1));
    e = exp_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL reset: got %b expected %b", o, e); end
    reset_n = 1'b1;
    sched(0,0,0,0,0, ST_OFF, OWN_NONE);
    sched(0,0,0,0,0, ST_OFF, OWN_NONE);
    for (int i = 0; stim_q.size() != 0; i++) begin
      s = stim_q.pop_front(); drive(s); tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL reset_idle[%0d]: got %b expected %b", i, o, e); end
    end
  endtask

  task automatic test_powerup();
    repeat (8) sched(1,0,0,0,0, ST_RAMP,  OWN_NONE);
    repeat (4) sched(1,0,0,0,0, ST_RESET, OWN_NONE);
    repeat (2) sched(1,0,0,0,0, ST_RUN,   OWN_NONE);
    for (int i = 0; stim_q.size() != 0; i++) begin
      s = stim_q.pop_front(); drive(s); tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL powerup[%0d]: got %b expected %b", i, o, e); end
    end
  endtask

  task automatic test_handover();
    sched(1,0,1,0,0, ST_RUN, OWN_NONE);
    sched(1,0,1,0,0, ST_RUN, OWN_NONE);
    sched(1,0,1,0,0, ST_RUN, OWN_GPIO);
    sched(1,0,1,1,0, ST_RUN, OWN_GPIO);
    sched(1,1,1,1,0, ST_RUN, OWN_NONE);
    sched(1,1,1,1,0, ST_RUN, OWN_NONE);
    sched(1,1,1,1,0, ST_RUN, OWN_AVR);
    sched(1,1,1,1,0, ST_RUN, OWN_AVR);
    sched(1,0,1,1,0, ST_RUN, OWN_NONE);
    sched(1,0,1,1,0, ST_RUN, OWN_NONE);
    sched(1,0,1,1,0, ST_RUN, OWN_GPIO);
    for (int i = 0; stim_q.size() != 0; i++) begin
      s = stim_q.pop_front(); drive(s); tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL handover[%0d]: got %b expected %b", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    sched(1,1,0,1,0, ST_RUN, OWN_NONE);
    sched(1,0,1,1,0, ST_RUN, OWN_NONE);
    sched(1,0,1,1,0, ST_RUN, OWN_GPIO);
    sched(1,1,1,1,0, ST_RUN, OWN_NONE);
    sched(1,0,0,1,0, ST_RUN, OWN_NONE);
    sched(1,0,0,1,0, ST_RUN, OWN_NONE);
    sched(1,0,0,1,0, ST_RUN, OWN_NONE);
    sched(1,0,1,1,0, ST_RUN, OWN_NONE);
    sched(1,0,1,1,0, ST_RUN, OWN_NONE);
    sched(1,0,1,1,0, ST_RUN, OWN_GPIO);
    for (int i = 0; stim_q.size() != 0; i++) begin
      s = stim_q.pop_front(); drive(s); tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, o, e); end
    end
  endtask

  task automatic test_poweroff_gap();
    sched(1,1,1,1,0, ST_RUN,   OWN_NONE);
    sched(0,1,1,1,0, ST_DRAIN, OWN_NONE);
    sched(1,0,0,1,0, ST_DRAIN, OWN_NONE);
    sched(1,0,0,1,0, ST_DRAIN, OWN_NONE);
    sched(1,0,0,1,0, ST_OFF,   OWN_NONE);
    sched(1,0,0,1,0, ST_RAMP,  OWN_NONE);
    for (int i = 0; stim_q.size() != 0; i++) begin
      s = stim_q.pop_front(); drive(s); tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL poweroff_gap[%0d]: got %b expected %b", i, o, e); end
    end
  endtask

  task automatic test_async_reset();
    repeat (7) sched(1,0,0,1,0, ST_RAMP,  OWN_NONE);
    repeat (2) sched(1,0,0,1,0, ST_RESET, OWN_NONE);
    for (int i = 0; stim_q.size() != 0; i++) begin
      s = stim_q.pop_front(); drive(s); tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL async_pre[%0d]: got %b expected %b", i, o, e); end
    end
    #2 reset_n = 1'b0;
    #1;
    exp_q.push_back(model(ST_OFF, OWN_NONE, 1'b1));
    e = exp_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL async_assert: got %b expected %b", o, e); end
    sched(0,0,0,1,0, ST_OFF, OWN_NONE);
    for (int i = 0; stim_q.size() != 0; i++) begin
      s = stim_q.pop_front(); drive(s); tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL async_held[%0d]: got %b expected %b", i, o, e); end
    end
    reset_n = 1'b1;
    repeat (3) sched(0,0,0,1,0, ST_OFF,  OWN_NONE);
    sched(1,0,0,1,0, ST_RAMP, OWN_NONE);
    for (int i = 0; stim_q.size() != 0; i++) begin
      s = stim_q.pop_front(); drive(s); tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL async_release[%0d]: got %b expected %b", i, o, e); end
    end
  endtask

`ifdef TARGET_SEQ_OVERCURRENT_EN
  task automatic test_fault();
    repeat (7) sched(1,0,0,1,0, ST_RAMP,  OWN_NONE);
    repeat (4) sched(1,0,0,1,0, ST_RESET, OWN_NONE);
    sched(1,0,0,1,0, ST_RUN,   OWN_NONE);
    sched(1,0,0,1,1, ST_FAULT, OWN_NONE);
    repeat (3) sched(1,0,0,1,0, ST_FAULT, OWN_NONE);
    sched(0,0,0,1,0, ST_OFF,   OWN_NONE);
    sched(1,0,0,1,0, ST_RAMP,  OWN_NONE);
    sched(0,0,0,1,1, ST_FAULT, OWN_NONE);
    sched(0,0,0,1,0, ST_OFF,   OWN_NONE);
    for (int i = 0; stim_q.size() != 0; i++) begin
      s = stim_q.pop_front(); drive(s); tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL fault[%0d]: got %b expected %b", i, o, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_handover();
    test_back_to_back();
    test_poweroff_gap();
    test_async_reset();
`ifdef TARGET_SEQ_OVERCURRENT_EN
    test_fault();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
